// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer for the multi-cycle MIPS core: owns the PC, fetches over req/ack, hands words to decode.
// Define EXC_PC_EN to add the exception redirect (exc input, epc output, EXC_VECTOR parameter).
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
`ifdef EXC_PC_EN
    ,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [15:0] immi16,
    input  logic [25:0] target
`ifdef EXC_PC_EN
    ,
    input  logic        exc,
    output logic [31:0] epc
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] inst_nxt;
    logic [31:0] inst_pc_nxt;
    logic [31:0] seq_pc;
    logic [31:0] br_pc;
    logic [31:0] jmp_pc;
    logic [31:0] npc;
`ifdef EXC_PC_EN
    logic [31:0] epc_nxt;
`endif

    assign imem_addr = pc;

    // Next-PC candidates are all derived from the held inst_pc, never from pc.
    assign seq_pc = inst_pc + 32'd4;
    assign br_pc  = seq_pc + {{14{immi16[15]}}, immi16, 2'b00};
    assign jmp_pc = {inst_pc[31:28], target, 2'b00};

    always_comb begin
        npc = seq_pc;
`ifdef EXC_PC_EN
        if (exc) begin
            npc = EXC_VECTOR;
        end else
`endif
        if (Jump) begin
            npc = jmp_pc;
        end else if (Branch && Zero) begin
            npc = br_pc;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        inst_nxt    = inst;
        inst_pc_nxt = inst_pc;
        imem_req    = 1'b0;
        inst_valid  = 1'b0;
`ifdef EXC_PC_EN
        epc_nxt     = epc;
`endif
        case (state)
            IDLE: begin
                if (!halt) begin
                    state_nxt = REQ;
                end
`ifdef EXC_PC_EN
                if (exc) begin
                    pc_nxt = EXC_VECTOR;
                end
`endif
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    inst_nxt    = imem_rdata;
                    inst_pc_nxt = pc;
                    state_nxt   = HOLD;
                end
            end
            HOLD: begin
                inst_valid = 1'b1;
                // Control inputs from decode are only meaningful in this accept cycle.
                if (inst_ready) begin
                    pc_nxt    = npc;
                    state_nxt = halt ? IDLE : REQ;
`ifdef EXC_PC_EN
                    if (exc) begin
                        epc_nxt = inst_pc;
                    end
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            inst    <= '0;
            inst_pc <= '0;
`ifdef EXC_PC_EN
            epc     <= '0;
`endif
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            inst    <= inst_nxt;
            inst_pc <= inst_pc_nxt;
`ifdef EXC_PC_EN
            epc     <= epc_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: expected fetch addresses are queued at each accept and popped at the next request.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        Jump = 1'b0;
    logic        Branch = 1'b0;
    logic        Zero = 1'b0;
    logic [15:0] immi16 = '0;
    logic [25:0] target = '0;
`ifdef EXC_PC_EN
    logic        exc = 1'b0;
    logic [31:0] epc;
`endif

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    logic [31:0] exp_q[$];

    logic        t_to;
    logic [31:0] t_addr;
    int          t_cyc;
    logic        t_rs;
    logic [31:0] t_inst;
    logic [31:0] t_pc;
    logic        t_val;
    logic        t_hs;
    logic        t_va;

    typedef struct packed {
        logic        j;
        logic        b;
        logic        z;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] nxt;
    } step_t;

    pc_fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .halt       (halt),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .Jump       (Jump),
        .Branch     (Branch),
        .Zero       (Zero),
        .immi16     (immi16),
        .target     (target)
`ifdef EXC_PC_EN
        ,
        .exc        (exc),
        .epc        (epc)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC001};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_ctrl();
        Jump   = 1'($urandom_range(0, 1));
        Branch = 1'($urandom_range(0, 1));
        Zero   = 1'($urandom_range(0, 1));
        immi16 = 16'($urandom);
        target = 26'($urandom);
    endtask

    // Plays memory and decode for one instruction; only observes, the calling test compares.
    task automatic do_xact(
        input  int          ack_dly,
        input  int          rdy_dly,
        input  logic        j,
        input  logic        b,
        input  logic        z,
        input  logic [15:0] imm,
        input  logic [25:0] tgt,
        output logic        timeout,
        output logic [31:0] req_addr,
        output int          req_cyc,
        output logic        req_stable,
        output logic [31:0] got_inst,
        output logic [31:0] got_pc,
        output logic        got_valid,
        output logic        hold_stable,
        output logic        valid_after
    );
        int n;
        timeout     = 1'b0;
        req_stable  = 1'b1;
        hold_stable = 1'b1;
        got_valid   = 1'b0;
        valid_after = 1'b1;
        req_addr    = 'x;
        got_inst    = 'x;
        got_pc      = 'x;
        req_cyc     = 0;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (imem_req !== 1'b1) begin
            timeout = 1'b1;
        end else begin
            req_addr = imem_addr;
            req_cyc  = cycle;
            for (int i = 0; i < ack_dly; i++) begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                scramble_ctrl();
                tick();
                if (imem_req !== 1'b1 || imem_addr !== req_addr) req_stable = 1'b0;
            end
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            tick();
            imem_ack  = 1'b0;
            got_valid = inst_valid;
            got_inst  = inst;
            got_pc    = inst_pc;
            for (int i = 0; i < rdy_dly; i++) begin
                inst_ready = 1'b0;
                imem_ack   = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
                scramble_ctrl();
                tick();
                if (inst_valid !== 1'b1 || inst !== got_inst || inst_pc !== got_pc || imem_req !== 1'b0)
                    hold_stable = 1'b0;
            end
            imem_ack   = 1'b0;
            inst_ready = 1'b1;
            Jump       = j;
            Branch     = b;
            Zero       = z;
            immi16     = imm;
            target     = tgt;
            tick();
            inst_ready  = 1'b0;
            scramble_ctrl();
            valid_after = inst_valid;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        halt = 1'b0;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", inst_valid); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00000000", imem_addr); end
        checks++; if (inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected 00000000", inst); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst_pc: got %h expected 00000000", inst_pc); end
`ifdef EXC_PC_EN
        checks++; if (epc !== 32'h0) begin errors++; $display("[TB] FAIL reset_epc: got %h expected 00000000", epc); end
`endif
        rst = 1'b0;
        exp_q.push_back(32'h0);
    endtask

    task automatic test_sequential();
        logic [31:0] exp_a;
        int prev_cyc;
        prev_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            do_xact(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, t_to, t_addr, t_cyc, t_rs, t_inst, t_pc, t_val, t_hs, t_va);
            exp_a = exp_q.pop_front();
            checks++; if (t_to !== 1'b0) begin errors++; $display("[TB] FAIL seq_timeout[%0d]: no request seen", k); end
            checks++; if (t_addr !== exp_a) begin errors++; $display("[TB] FAIL seq_addr[%0d]: got %h expected %h", k, t_addr, exp_a); end
            checks++; if (t_val !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid[%0d]: got %b expected 1", k, t_val); end
            checks++; if (t_pc !== exp_a) begin errors++; $display("[TB] FAIL seq_inst_pc[%0d]: got %h expected %h", k, t_pc, exp_a); end
            checks++; if (t_inst !== mem_word(exp_a)) begin errors++; $display("[TB] FAIL seq_inst[%0d]: got %h expected %h", k, t_inst, mem_word(exp_a)); end
            checks++; if (t_va !== 1'b0) begin errors++; $display("[TB] FAIL seq_valid_drop[%0d]: got %b expected 0", k, t_va); end
            if (k > 0) begin
                checks++; if (t_cyc - prev_cyc !== 2) begin errors++; $display("[TB] FAIL fetch_spacing[%0d]: got %0d cycles expected 2", k, t_cyc - prev_cyc); end
            end
            prev_cyc = t_cyc;
            exp_q.push_back(exp_a + 32'd4);
        end
    endtask

    task automatic test_delayed_handshake();
        logic [31:0] exp_a;
        do_xact(4, 2, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, t_to, t_addr, t_cyc, t_rs, t_inst, t_pc, t_val, t_hs, t_va);
        exp_a = exp_q.pop_front();
        checks++; if (t_to !== 1'b0) begin errors++; $display("[TB] FAIL dly_timeout: no request seen"); end
        checks++; if (t_addr !== exp_a) begin errors++; $display("[TB] FAIL dly_addr: got %h expected %h", t_addr, exp_a); end
        checks++; if (t_rs !== 1'b1) begin errors++; $display("[TB] FAIL dly_req_stable: got %b expected 1", t_rs); end
        checks++; if (t_hs !== 1'b1) begin errors++; $display("[TB] FAIL dly_hold_stable: got %b expected 1", t_hs); end
        checks++; if (t_inst !== mem_word(exp_a)) begin errors++; $display("[TB] FAIL dly_inst: got %h expected %h", t_inst, mem_word(exp_a)); end
        checks++; if (t_va !== 1'b0) begin errors++; $display("[TB] FAIL dly_valid_drop: got %b expected 0", t_va); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL dly_next_req: got %b expected 1", imem_req); end
        exp_q.push_back(exp_a + 32'd4);
    endtask

    task automatic test_branch();
        step_t tbl [5];
        logic [31:0] exp_a;
        tbl[0] = '{j:1'b1, b:1'b0, z:1'b0, imm:16'h0000, tgt:26'h0000040, nxt:32'h0000_0100};
        tbl[1] = '{j:1'b0, b:1'b1, z:1'b1, imm:16'hFFFE, tgt:26'h3FFFFFF, nxt:32'h0000_00FC};
        tbl[2] = '{j:1'b1, b:1'b0, z:1'b1, imm:16'h1234, tgt:26'h0000040, nxt:32'h0000_0100};
        tbl[3] = '{j:1'b0, b:1'b1, z:1'b0, imm:16'hFFFE, tgt:26'h0000000, nxt:32'h0000_0104};
        tbl[4] = '{j:1'b0, b:1'b0, z:1'b1, imm:16'h0100, tgt:26'h0000010, nxt:32'h0000_0108};
        for (int k = 0; k < 5; k++) begin
            do_xact(k % 3, (k + 1) % 3, tbl[k].j, tbl[k].b, tbl[k].z, tbl[k].imm, tbl[k].tgt,
                    t_to, t_addr, t_cyc, t_rs, t_inst, t_pc, t_val, t_hs, t_va);
            exp_a = exp_q.pop_front();
            checks++; if (t_to !== 1'b0) begin errors++; $display("[TB] FAIL br_timeout[%0d]: no request seen", k); end
            checks++; if (t_addr !== exp_a) begin errors++; $display("[TB] FAIL br_addr[%0d]: got %h expected %h", k, t_addr, exp_a); end
            checks++; if (t_pc !== exp_a) begin errors++; $display("[TB] FAIL br_inst_pc[%0d]: got %h expected %h", k, t_pc, exp_a); end
            checks++; if (t_inst !== mem_word(exp_a)) begin errors++; $display("[TB] FAIL br_inst[%0d]: got %h expected %h", k, t_inst, mem_word(exp_a)); end
            exp_q.push_back(tbl[k].nxt);
        end
    endtask

    task automatic test_wrap_and_jump_priority();
        step_t tbl [5];
        logic [31:0] exp_a;
        tbl[0] = '{j:1'b0, b:1'b1, z:1'b1, imm:16'hFFBC, tgt:26'h0000000, nxt:32'hFFFF_FFFC};
        tbl[1] = '{j:1'b0, b:1'b0, z:1'b0, imm:16'h0000, tgt:26'h0000000, nxt:32'h0000_0000};
        tbl[2] = '{j:1'b0, b:1'b1, z:1'b1, imm:16'hFFFE, tgt:26'h0000000, nxt:32'hFFFF_FFFC};
        tbl[3] = '{j:1'b1, b:1'b1, z:1'b1, imm:16'h0010, tgt:26'h0000040, nxt:32'hF000_0100};
        tbl[4] = '{j:1'b0, b:1'b0, z:1'b0, imm:16'h0000, tgt:26'h0000000, nxt:32'hF000_0104};
        for (int k = 0; k < 5; k++) begin
            do_xact(0, k % 2, tbl[k].j, tbl[k].b, tbl[k].z, tbl[k].imm, tbl[k].tgt,
                    t_to, t_addr, t_cyc, t_rs, t_inst, t_pc, t_val, t_hs, t_va);
            exp_a = exp_q.pop_front();
            checks++; if (t_to !== 1'b0) begin errors++; $display("[TB] FAIL wrap_timeout[%0d]: no request seen", k); end
            checks++; if (t_addr !== exp_a) begin errors++; $display("[TB] FAIL wrap_addr[%0d]: got %h expected %h", k, t_addr, exp_a); end
            checks++; if (t_pc !== exp_a) begin errors++; $display("[TB] FAIL wrap_inst_pc[%0d]: got %h expected %h", k, t_pc, exp_a); end
            exp_q.push_back(tbl[k].nxt);
        end
    endtask

    task automatic test_halt();
        logic [31:0] exp_a;
        logic parked;
        halt = 1'b1;
        do_xact(2, 1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, t_to, t_addr, t_cyc, t_rs, t_inst, t_pc, t_val, t_hs, t_va);
        exp_a = exp_q.pop_front();
        checks++; if (t_to !== 1'b0) begin errors++; $display("[TB] FAIL halt_timeout: no request seen"); end
        checks++; if (t_addr !== exp_a) begin errors++; $display("[TB] FAIL halt_fetch_addr: got %h expected %h", t_addr, exp_a); end
        checks++; if (t_val !== 1'b1) begin errors++; $display("[TB] FAIL halt_fetch_done: got %b expected 1", t_val); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_req_drop: got %b expected 0", imem_req); end
        parked = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (imem_req !== 1'b0 || inst_valid !== 1'b0) parked = 1'b0;
        end
        checks++; if (parked !== 1'b1) begin errors++; $display("[TB] FAIL halt_parked: got %b expected 1", parked); end
        checks++; if (imem_addr !== exp_a + 32'd4) begin errors++; $display("[TB] FAIL halt_parked_addr: got %h expected %h", imem_addr, exp_a + 32'd4); end
        exp_q.push_back(exp_a + 32'd4);
        halt = 1'b0;
        do_xact(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, t_to, t_addr, t_cyc, t_rs, t_inst, t_pc, t_val, t_hs, t_va);
        exp_a = exp_q.pop_front();
        checks++; if (t_addr !== exp_a) begin errors++; $display("[TB] FAIL halt_resume_addr: got %h expected %h", t_addr, exp_a); end
        exp_q.push_back(exp_a + 32'd4);
    endtask

    task automatic test_reset_mid_request();
        logic [31:0] exp_a;
        imem_ack = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rstreq_pending: got %b expected 1", imem_req); end
        rst        = 1'b1;
        halt       = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstreq_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rstreq_addr: got %h expected 00000000", imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstreq_valid: got %b expected 0", inst_valid); end
        tick();
        tick();
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstreq_late_ack: got valid=%b req=%b expected 0 0", inst_valid, imem_req); end
        checks++; if (inst !== 32'h0) begin errors++; $display("[TB] FAIL rstreq_inst: got %h expected 00000000", inst); end
        imem_ack = 1'b0;
        halt     = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        do_xact(1, 0, 1'b1, 1'b0, 1'b0, 16'h0, 26'h0000010, t_to, t_addr, t_cyc, t_rs, t_inst, t_pc, t_val, t_hs, t_va);
        exp_a = exp_q.pop_front();
        checks++; if (t_addr !== exp_a) begin errors++; $display("[TB] FAIL rstreq_restart_addr: got %h expected %h", t_addr, exp_a); end
        checks++; if (t_inst !== mem_word(exp_a)) begin errors++; $display("[TB] FAIL rstreq_restart_inst: got %h expected %h", t_inst, mem_word(exp_a)); end
        exp_q.push_back(32'h0000_0040);
    endtask

`ifdef EXC_PC_EN
    task automatic test_exception();
        logic [31:0] exp_a;
        exc = 1'b1;
        do_xact(0, 0, 1'b1, 1'b1, 1'b1, 16'h0004, 26'h0000003, t_to, t_addr, t_cyc, t_rs, t_inst, t_pc, t_val, t_hs, t_va);
        exc = 1'b0;
        exp_a = exp_q.pop_front();
        checks++; if (t_addr !== exp_a) begin errors++; $display("[TB] FAIL exc_fetch_addr: got %h expected %h", t_addr, exp_a); end
        checks++; if (epc !== 32'h0000_0040) begin errors++; $display("[TB] FAIL exc_epc: got %h expected 00000040", epc); end
        exp_q.push_back(32'h0000_0180);
        halt = 1'b1;
        do_xact(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, t_to, t_addr, t_cyc, t_rs, t_inst, t_pc, t_val, t_hs, t_va);
        exp_a = exp_q.pop_front();
        checks++; if (t_addr !== exp_a) begin errors++; $display("[TB] FAIL exc_vector_addr: got %h expected %h", t_addr, exp_a); end
        checks++; if (imem_addr !== 32'h0000_0184) begin errors++; $display("[TB] FAIL exc_parked_addr: got %h expected 00000184", imem_addr); end
        exc = 1'b1;
        tick();
        exc = 1'b0;
        checks++; if (imem_addr !== 32'h0000_0180) begin errors++; $display("[TB] FAIL exc_idle_addr: got %h expected 00000180", imem_addr); end
        checks++; if (epc !== 32'h0000_0040) begin errors++; $display("[TB] FAIL exc_idle_epc: got %h expected 00000040", epc); end
        halt = 1'b0;
        exp_q.push_back(32'h0000_0180);
        do_xact(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, t_to, t_addr, t_cyc, t_rs, t_inst, t_pc, t_val, t_hs, t_va);
        exp_a = exp_q.pop_front();
        checks++; if (t_addr !== exp_a) begin errors++; $display("[TB] FAIL exc_resume_addr: got %h expected %h", t_addr, exp_a); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_delayed_handshake();
        test_branch();
        test_wrap_and_jump_priority();
        test_halt();
        test_reset_mid_request();
`ifdef EXC_PC_EN
        test_exception();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
